// File: rtl/fifo_wr_engine.sv
// -----------------------------------------------------------------------------
// fifo_wr_engine
//
// Streams user FIFO data into host memory as fixed 128-byte (16 x 64-bit)
// write bursts. Software loads 4 KiB host page addresses into a small ring;
// the engine walks each page as 32 consecutive bursts and then retires it.
// A burst is offered downstream only once the FIFO already holds all 16
// words, so the outgoing stream never stalls mid-burst.
//
// Optional feature macro: FIFO_WR_ENGINE_STATS_EN
//   defined   -> stall_cycles counts wr_valid && !wr_ready cycles (saturating)
//   undefined -> stall_cycles is tied to 0 and no counter is built
//
// Parameters
//   NPAGES      page-table ring depth (power of 2, >= 2)
//   LEVEL_BITS  width of fifo_level
//
// Ports
//   clock         sole clock
//   reset         asynchronous active-low reset
//   enable        permits starting new bursts
//   pa_data       host page physical address (bits [11:0] ignored)
//   pa_valid      write pa_data into the ring at the write pointer
//   pa_free       number of free ring entries
//   fifo_data     FWFT FIFO head word
//   fifo_level    FIFO occupancy in words
//   fifo_read     FIFO pop strobe
//   wr_valid      a burst is ready to start
//   wr_ready      one-cycle burst-accept strobe
//   wr_addr       burst byte address
//   wr_data       burst data word
//   wr_last       final word of a burst
//   bytes_done    bytes written, modulo 2^32
//   stall_cycles  cycles spent offering a burst that was not accepted
// -----------------------------------------------------------------------------
module fifo_wr_engine #(
   parameter int NPAGES     = 16,
   parameter int LEVEL_BITS = 10
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [63:0]             pa_data,
   input  logic                    pa_valid,
   output logic [$clog2(NPAGES):0] pa_free,
   input  logic [63:0]             fifo_data,
   input  logic [LEVEL_BITS-1:0]   fifo_level,
   output logic                    fifo_read,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [63:0]             wr_addr,
   output logic [63:0]             wr_data,
   output logic                    wr_last,
   output logic [31:0]             bytes_done,
   output logic [31:0]             stall_cycles
);

   localparam int PTR_W = $clog2(NPAGES);
   localparam int CNT_W = PTR_W + 1;

   // Words that must be resident in the FIFO before a burst is offered.
   localparam logic [LEVEL_BITS-1:0] BURST_WORDS = LEVEL_BITS'(16);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_STREAM,
      S_NEXT
   } state_t;

   state_t state, state_nxt;

   // Page ring: only addr[63:12] of each page is kept.
   logic [51:0]      ring [NPAGES];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;

   logic [4:0]       burst_idx;   // burst within the current page (32 per page)
   logic [3:0]       beat;        // word within the current burst
   logic [31:0]      bytes_cnt;

   logic             ring_full;
   logic             pa_accept;
   logic             retire;
   logic             level_ok;
   logic             start_ok;
   logic             restart_ok;
   logic [CNT_W-1:0] count_post_retire;

   // Low page-offset bits of pa_data carry no information for a page ring.
   logic             unused_pa_low;
   assign unused_pa_low = ^pa_data[11:0];

   // --------------------------------------------------------------------------
   // Control terms
   // --------------------------------------------------------------------------
   assign ring_full = (count == CNT_W'(NPAGES));
   // A full ring drops the write outright, even if a retire frees a slot in
   // the same cycle.
   assign pa_accept = pa_valid && !ring_full;
   assign retire    = (state == S_NEXT) && (burst_idx == 5'd31);
   assign level_ok  = (fifo_level >= BURST_WORDS);
   assign start_ok  = enable && (count != '0) && level_ok;

   // Continuing from NEXT must see the ring as it will be after this page
   // retires, otherwise a burst could be armed against an empty ring.
   assign count_post_retire = count - CNT_W'(retire);
   assign restart_ok        = enable && (count_post_retire != '0) && level_ok;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update together from the values sampled at the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   // NOTE: the default assignment at the top keeps every path assigned, so no
   // latch is inferred from an incomplete case or if.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:   if (start_ok) state_nxt = S_ARM;
         S_ARM:    if (wr_ready) state_nxt = S_STREAM;
         S_STREAM: if (beat == 4'd15) state_nxt = S_NEXT;
         S_NEXT:   state_nxt = restart_ok ? S_ARM : S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   // wr_addr is driven only while a burst is armed or streaming; this keeps it
   // 0 in reset/idle even though the ring storage itself is never cleared.
   always_comb begin
      wr_valid  = 1'b0;
      fifo_read = 1'b0;
      wr_data   = '0;
      wr_last   = 1'b0;
      wr_addr   = '0;
      unique case (state)
         S_ARM: begin
            wr_valid = 1'b1;
            wr_addr  = {ring[rptr], burst_idx, 7'b0};
         end
         S_STREAM: begin
            fifo_read = 1'b1;
            wr_data   = fifo_data;
            wr_last   = (beat == 4'd15);
            wr_addr   = {ring[rptr], burst_idx, 7'b0};
         end
         default: ;
      endcase
   end

   // --------------------------------------------------------------------------
   // Page ring storage
   // --------------------------------------------------------------------------
   // NOTE: the ring entries carry no reset; valid/invalid is tracked entirely
   // by count and the pointers, so clearing the storage would buy nothing.
   always_ff @(posedge clock) begin
      if (pa_accept) ring[wptr] <= pa_data[63:12];
   end

   // --------------------------------------------------------------------------
   // Ring pointers and occupancy
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (pa_accept) wptr <= wptr + 1'b1;
         if (retire)    rptr <= rptr + 1'b1;
         // A simultaneous write and retire leaves the occupancy unchanged.
         unique case ({pa_accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign pa_free = CNT_W'(NPAGES) - count;

   // --------------------------------------------------------------------------
   // Burst / beat position and byte counter
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         burst_idx <= '0;
         beat      <= '0;
         bytes_cnt <= '0;
      end else begin
         // beat is held at 0 outside STREAM so each burst starts at word 0.
         if (state == S_STREAM) beat <= beat + 1'b1;
         else                   beat <= '0;

         if (state == S_NEXT) begin
            // burst_idx wraps 31 -> 0 on its own as the page retires.
            burst_idx <= burst_idx + 1'b1;
            bytes_cnt <= bytes_cnt + 32'd128;
         end
      end
   end

   assign bytes_done = bytes_cnt;

   // --------------------------------------------------------------------------
   // Optional stall statistics
   // --------------------------------------------------------------------------
`ifdef FIFO_WR_ENGINE_STATS_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
      end else if (wr_valid && !wr_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_engine.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_engine
//
// Directed self-checking bench for fifo_wr_engine. The FIFO is modelled as an
// infinite source whose head word equals the number of words already popped,
// so burst data is a simple running index. Inputs are driven and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_engine;

   localparam int NPAGES     = 16;
   localparam int LEVEL_BITS = 10;

`ifdef FIFO_WR_ENGINE_STATS_EN
   localparam logic [63:0] EXP_STALL = 64'd7;
`else
   localparam logic [63:0] EXP_STALL = 64'd0;
`endif

   logic                    clock    = 1'b0;
   logic                    reset    = 1'b0;
   logic                    enable   = 1'b0;
   logic [63:0]             pa_data  = '0;
   logic                    pa_valid = 1'b0;
   logic                    wr_ready = 1'b0;
   logic [$clog2(NPAGES):0] pa_free;
   logic [63:0]             fifo_data;
   logic [LEVEL_BITS-1:0]   fifo_level;
   logic                    fifo_read;
   logic                    wr_valid;
   logic [63:0]             wr_addr;
   logic [63:0]             wr_data;
   logic                    wr_last;
   logic [31:0]             bytes_done;
   logic [31:0]             stall_cycles;

   int pushed = 0;   // words ever written into the modelled FIFO
   int popped = 0;   // words popped by the DUT
   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   fifo_wr_engine #(
      .NPAGES    (NPAGES),
      .LEVEL_BITS(LEVEL_BITS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .pa_data     (pa_data),
      .pa_valid    (pa_valid),
      .pa_free     (pa_free),
      .fifo_data   (fifo_data),
      .fifo_level  (fifo_level),
      .fifo_read   (fifo_read),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_last     (wr_last),
      .bytes_done  (bytes_done),
      .stall_cycles(stall_cycles)
   );

   // FWFT FIFO model: head word is the running word index.
   always @(posedge clock or negedge reset) begin
      if (!reset)         popped <= 0;
      else if (fifo_read) popped <= popped + 1;
   end

   assign fifo_level = LEVEL_BITS'(pushed - popped);
   assign fifo_data  = 64'(popped);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      enable   = 1'b0;
      pa_valid = 1'b0;
      wr_ready = 1'b0;
      pushed   = 0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic load_page(input logic [63:0] addr);
      pa_valid = 1'b1;
      pa_data  = addr;
      @(negedge clock);
      pa_valid = 1'b0;
   endtask

   task automatic check_quiet(input string tag, input logic [63:0] exp_free);
      check({tag, "_valid"},  64'(wr_valid),     64'd0);
      check({tag, "_read"},   64'(fifo_read),    64'd0);
      check({tag, "_last"},   64'(wr_last),      64'd0);
      check({tag, "_data"},   wr_data,           64'd0);
      check({tag, "_addr"},   wr_addr,           64'd0);
      check({tag, "_free"},   64'(pa_free),      exp_free);
   endtask

   // Waits (bounded) for wr_valid, optionally stalls, accepts the burst and
   // checks every beat. Returns at the falling edge inside NEXT, or right
   // after an asynchronous reset when rst_beat is reached.
   task automatic run_burst(input logic [63:0] addr, input int first,
                            input int stall_n, input int drop_beat, input int rst_beat);
      int n = 0;
      while (wr_valid !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      check("burst_valid", 64'(wr_valid), 64'd1);
      check("burst_addr", wr_addr, addr);
      if (stall_n > 0) begin
         repeat (stall_n) @(negedge clock);
         check("stall_cycles", 64'(stall_cycles), EXP_STALL);
         check("stall_valid_held", 64'(wr_valid), 64'd1);
      end
      wr_ready = 1'b1;
      @(negedge clock);
      wr_ready = 1'b0;
      for (int b = 0; b < 16; b++) begin
         check($sformatf("beat%0d_data", b),  wr_data, 64'(first + b));
         check($sformatf("beat%0d_last", b),  64'(wr_last), 64'(b == 15));
         check($sformatf("beat%0d_read", b),  64'(fifo_read), 64'd1);
         check($sformatf("beat%0d_valid", b), 64'(wr_valid), 64'd0);
         check($sformatf("beat%0d_addr", b),  wr_addr, addr);
         if (b == drop_beat) enable = 1'b0;
         if (b == rst_beat) begin
            reset = 1'b0;
            #1;
            check_quiet("async_rst", 64'd16);
            check("async_rst_bytes", 64'(bytes_done), 64'd0);
            check("async_rst_stall", 64'(stall_cycles), 64'd0);
            return;
         end
         @(negedge clock);
      end
      check("next_read", 64'(fifo_read), 64'd0);
      check("next_last", 64'(wr_last), 64'd0);
      check("next_data", wr_data, 64'd0);
   endtask

   localparam logic [63:0] PAGE_0 = 64'h0000_0001_2345_6000;
   localparam logic [63:0] PAGE_A = 64'h0000_00AB_CDE0_1000;
   localparam logic [63:0] PAGE_B = 64'h0000_0000_0000_3000;
   localparam logic [63:0] PAGE_C = 64'h0000_0000_0000_7000;
   localparam logic [63:0] PAGE_D = 64'h0000_0000_0004_0000;

   initial begin
      int bad;

      // ---------------- reset state ----------------
      do_reset();
      check_quiet("reset", 64'd16);
      check("reset_bytes", 64'(bytes_done), 64'd0);
      check("reset_stall", 64'(stall_cycles), 64'd0);

      // ---------------- level threshold ----------------
      pushed = 15;
      enable = 1'b1;
      load_page(PAGE_0 | 64'hABC);   // low 12 bits must be ignored
      check("load_free", 64'(pa_free), 64'd15);
      bad = 0;
      repeat (100) begin
         @(negedge clock);
         if (wr_valid !== 1'b0) bad++;
      end
      check("lvl15_no_valid", 64'(bad), 64'd0);
      pushed = 16;                   // conditions true in this cycle C
      #1;
      check("lvl16_same_cycle", 64'(wr_valid), 64'd0);
      @(negedge clock);              // cycle C+1
      check("lvl16_valid", 64'(wr_valid), 64'd1);
      check("lvl16_addr", wr_addr, PAGE_0);

      // ---------------- first burst ----------------
      run_burst(PAGE_0, 0, 0, -1, -1);
      check("b0_next_bytes", 64'(bytes_done), 64'd0);
      @(negedge clock);
      check("b0_bytes", 64'(bytes_done), 64'd128);
      check("b0_idle", 64'(wr_valid), 64'd0);
      check("b0_free", 64'(pa_free), 64'd15);
      check("b0_popped", 64'(popped), 64'd16);

      // ---------------- rest of the page ----------------
      pushed = 512;
      for (int k = 1; k < 32; k++)
         run_burst(PAGE_0 + 64'(k) * 64'h80, 16 * k, 0, -1, -1);
      @(negedge clock);
      check("page_free", 64'(pa_free), 64'd16);
      check("page_bytes", 64'(bytes_done), 64'd4096);
      check("page_idle", 64'(wr_valid), 64'd0);
      pushed = 528;                  // data present but ring empty
      bad = 0;
      repeat (5) begin
        @(negedge clock);
        if (wr_valid !== 1'b0) bad++;
      end
      check("empty_ring_no_valid", 64'(bad), 64'd0);

      // ---------------- retire with simultaneous write ----------------
      pushed = 1040;
      load_page(PAGE_A);
      load_page(PAGE_B);
      check("two_pages_free", 64'(pa_free), 64'd14);
      for (int k = 0; k < 32; k++)
         run_burst(PAGE_A + 64'(k) * 64'h80, 512 + 16 * k, 0, -1, -1);
      pa_valid = 1'b1;               // write lands in the retire cycle
      pa_data  = PAGE_C;
      @(negedge clock);
      pa_valid = 1'b0;
      check("retire_write_free", 64'(pa_free), 64'd14);
      check("retire_bytes", 64'(bytes_done), 64'd8192);
      run_burst(PAGE_B, 1024, 0, -1, -1);
      @(negedge clock);
      check("page_b_bytes", 64'(bytes_done), 64'd8320);

      // ---------------- ring full ----------------
      enable   = 1'b0;
      pa_valid = 1'b1;
      for (int k = 0; k < 14; k++) begin
         pa_data = 64'(k + 16) << 12;
         @(negedge clock);
      end
      pa_valid = 1'b0;
      check("ring_full_free", 64'(pa_free), 64'd0);
      load_page(64'h0000_0000_00FF_F000);
      check("ring_drop_free", 64'(pa_free), 64'd0);

      // ---------------- enable drop mid-burst ----------------
      do_reset();
      pushed = 32;
      enable = 1'b1;
      load_page(PAGE_D);
      run_burst(PAGE_D, 0, 0, 5, -1);
      @(negedge clock);
      check("drop_bytes", 64'(bytes_done), 64'd128);
      bad = 0;
      repeat (20) begin
         @(negedge clock);
         if (wr_valid !== 1'b0) bad++;
      end
      check("drop_no_valid", 64'(bad), 64'd0);
      check("drop_free", 64'(pa_free), 64'd15);

      // ---------------- stall count, then reset at beat 5 ----------------
      enable = 1'b1;
      run_burst(PAGE_D + 64'h80, 16, 7, -1, 5);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      bad = 0;
      repeat (10) begin
         @(negedge clock);
         if (wr_valid !== 1'b0) bad++;
      end
      check("post_rst_no_valid", 64'(bad), 64'd0);
      check("post_rst_free", 64'(pa_free), 64'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
